// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: steers PC, IR, memory,
// register file and ALU through FETCH/DECODE/EXEC/MEM/WB and counts retirements.
module mc_control_fsm #(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(4'hC);
  localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'hF);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end

  // Next state plus Mealy control outputs; strobes are squashed while rst is high.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HALT:                                  state_d = S_HALT;
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ:  state_d = S_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = 2'b10;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = 2'b01;
            pc_src   = 2'b01;
            pc_write = zero;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // The request is held unchanged until memory accepts it.
        i_or_d = 1'b1;
        if (opcode == OP_LW) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else begin
          mem_write = (opcode == OP_SW);
          if (mem_ready) begin
            retire  = (opcode == OP_SW);
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  assign halted_d  = (state_d == S_HALT);

  assign state   = state_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle vector table through a scoreboard queue,
// plus measured instruction sequences for waits, halt and mid-instruction reset.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [2:0]  state;
  logic        halted, illegal;
  logic [15:0] retired;
  logic [14:0] ctl;

  mc_control_fsm #(.OPC_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  // {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op}
  assign ctl = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  localparam logic [14:0] C_ZERO     = 15'd0;
  localparam logic [14:0] C_RST      = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
  localparam logic [14:0] C_F_WAIT   = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
  localparam logic [14:0] C_F_RDY    = {1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
  localparam logic [14:0] C_DEC      = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00};
  localparam logic [14:0] C_DEC_J    = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00};
  localparam logic [14:0] C_EX_R     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10};
  localparam logic [14:0] C_EX_I     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
  localparam logic [14:0] C_EX_BEQ_T = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
  localparam logic [14:0] C_EX_BEQ_N = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01};
  localparam logic [14:0] C_MEM_LW   = {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [14:0] C_MEM_SW   = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [14:0] C_MEM_RST  = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [14:0] C_WB_R     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [14:0] C_WB_I     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
  localparam logic [14:0] C_WB_LW    = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};

  typedef struct {
    logic        rst;
    logic [3:0]  opc;
    logic        zero;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] ctl;
    logic        halt;
    logic        ill;
    logic [15:0] ret;
  } vec_t;

  typedef struct {
    logic [3:0] opc;
    logic       zero;
    int         fwait;
    int         mwait;
    int         cycles;
  } ri_t;

  vec_t tbl[$];
  vec_t sb[$];
  ri_t  ri[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vec_id = 0;
  int   ret_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic [3:0] o, input logic z, input logic d,
                              input logic [2:0] s, input logic [14:0] c, input logic h,
                              input logic i, input int rt);
    vec_t v;
    v.rst = r; v.opc = o; v.zero = z; v.rdy = d;
    v.st = s; v.ctl = c; v.halt = h; v.ill = i; v.ret = 16'(rt);
    return v;
  endfunction

  function automatic ri_t mkr(input logic [3:0] o, input logic z, input int fw, input int mw, input int cy);
    ri_t r;
    r.opc = o; r.zero = z; r.fwait = fw; r.mwait = mw; r.cycles = cy;
    return r;
  endfunction

  task automatic check_out();
    vec_t e;
    e = sb.pop_front();
    n_vec++;
    if (state !== e.st || ctl !== e.ctl || halted !== e.halt || illegal !== e.ill || retired !== e.ret) begin
      n_err++;
      $display("FAIL vec%0d: state=%0d ctl=%b halted=%b illegal=%b retired=%0d, required state=%0d ctl=%b halted=%b illegal=%b retired=%0d",
               vec_id, state, ctl, halted, illegal, retired, e.st, e.ctl, e.halt, e.ill, e.ret);
    end
    vec_id++;
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    rst = v.rst; opcode = v.opc; zero = v.zero; mem_ready = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    check_out();
  endtask

  task automatic cmp(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Runs one instruction from FETCH with the given memory wait counts and measures its length.
  task automatic run_instr(input ri_t r);
    int  cyc = 0, irw = 0, fw = 0, mw = 0;
    bit  left = 0, done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      if (left && state == 3'd0) begin
        done = 1;
      end else begin
        rst = 1'b0;
        zero = r.zero;
        opcode = (state == 3'd0) ? 4'h7 : r.opc;
        if (state == 3'd0)      begin mem_ready = (fw >= r.fwait); fw++; end
        else if (state == 3'd3) begin mem_ready = (mw >= r.mwait); mw++; end
        else                    mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc++;
        irw += int'(ir_write);
        if (state != 3'd0) left = 1;
        if (state == 3'd0) begin
          cmp("fetch_mem_read", int'(mem_read), 1);
          cmp("fetch_i_or_d", int'(i_or_d), 0);
        end else if (state == 3'd3) begin
          cmp("mem_i_or_d", int'(i_or_d), 1);
          cmp("mem_strobe", int'(r.opc == 4'h4 ? mem_read : mem_write), 1);
        end
      end
    end
    opcode = 4'h7;
    mem_ready = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout opc=%h: no return to FETCH after %0d cycles, required %0d", r.opc, cyc, r.cycles);
    end else begin
      if (r.opc inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'hC}) ret_exp++;
      cmp($sformatf("cycles_opc%h", r.opc), cyc, r.cycles);
      cmp($sformatf("ir_write_pulses_opc%h", r.opc), irw, 1);
      cmp($sformatf("retired_opc%h", r.opc), int'(retired), ret_exp);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b1;

    tbl.push_back(mk(1, 4'h0, 0, 1, 3'd0, C_RST, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 3'd0, C_RST, 0, 0, 0));
    // R-type
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 3'd1, C_DEC,   0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 3'd2, C_EX_R,  0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 3'd4, C_WB_R,  0, 0, 0));
    // ADDI
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY, 0, 0, 1));
    tbl.push_back(mk(0, 4'h1, 0, 1, 3'd1, C_DEC,   0, 0, 1));
    tbl.push_back(mk(0, 4'h1, 0, 1, 3'd2, C_EX_I,  0, 0, 1));
    tbl.push_back(mk(0, 4'h1, 0, 1, 3'd4, C_WB_I,  0, 0, 1));
    // LW
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,  0, 0, 2));
    tbl.push_back(mk(0, 4'h4, 0, 1, 3'd1, C_DEC,    0, 0, 2));
    tbl.push_back(mk(0, 4'h4, 0, 1, 3'd2, C_EX_I,   0, 0, 2));
    tbl.push_back(mk(0, 4'h4, 0, 1, 3'd3, C_MEM_LW, 0, 0, 2));
    tbl.push_back(mk(0, 4'h4, 0, 1, 3'd4, C_WB_LW,  0, 0, 2));
    // SW
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,  0, 0, 3));
    tbl.push_back(mk(0, 4'h5, 0, 1, 3'd1, C_DEC,    0, 0, 3));
    tbl.push_back(mk(0, 4'h5, 0, 1, 3'd2, C_EX_I,   0, 0, 3));
    tbl.push_back(mk(0, 4'h5, 0, 1, 3'd3, C_MEM_SW, 0, 0, 3));
    // J
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY, 0, 0, 4));
    tbl.push_back(mk(0, 4'hC, 0, 1, 3'd1, C_DEC_J, 0, 0, 4));
    // BEQ taken, then not taken
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,    0, 0, 5));
    tbl.push_back(mk(0, 4'h8, 0, 1, 3'd1, C_DEC,      0, 0, 5));
    tbl.push_back(mk(0, 4'h8, 1, 1, 3'd2, C_EX_BEQ_T, 0, 0, 5));
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,    0, 0, 6));
    tbl.push_back(mk(0, 4'h8, 1, 1, 3'd1, C_DEC,      0, 0, 6));
    tbl.push_back(mk(0, 4'h8, 0, 1, 3'd2, C_EX_BEQ_N, 0, 0, 6));
    // illegal opcode: pulse, back to FETCH, count unchanged
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,  0, 0, 7));
    tbl.push_back(mk(0, 4'h7, 0, 1, 3'd1, C_DEC,    0, 1, 7));
    tbl.push_back(mk(0, 4'h7, 0, 0, 3'd0, C_F_WAIT, 0, 0, 7));

    foreach (tbl[i]) apply(tbl[i]);
    ret_exp = 7;

    ri.push_back(mkr(4'h0, 0, 0, 0, 4));
    ri.push_back(mkr(4'h1, 0, 0, 0, 4));
    ri.push_back(mkr(4'h4, 0, 0, 0, 5));
    ri.push_back(mkr(4'h5, 0, 0, 0, 4));
    ri.push_back(mkr(4'hC, 0, 0, 0, 2));
    ri.push_back(mkr(4'h8, 1, 0, 0, 3));
    ri.push_back(mkr(4'h8, 0, 0, 0, 3));
    ri.push_back(mkr(4'h4, 0, 3, 2, 10));
    ri.push_back(mkr(4'h7, 0, 0, 0, 2));
    ri.push_back(mkr(4'h5, 0, 1, 3, 8));
    foreach (ri[i]) run_instr(ri[i]);

    // HALT persists with no strobes until reset
    apply(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY, 0, 0, ret_exp));
    apply(mk(0, 4'hF, 0, 1, 3'd1, C_DEC,   0, 0, ret_exp));
    for (int i = 0; i < 20; i++)
      apply(mk(0, 4'hF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd5, C_ZERO, 1, 0, ret_exp));
    apply(mk(1, 4'hF, 0, 1, 3'd5, C_ZERO, 1, 0, ret_exp));
    apply(mk(1, 4'hF, 0, 1, 3'd0, C_RST,  0, 0, 0));

    // J retires, then reset lands in MEM of an SW
    apply(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,   0, 0, 0));
    apply(mk(0, 4'hC, 0, 1, 3'd1, C_DEC_J,   0, 0, 0));
    apply(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,   0, 0, 1));
    apply(mk(0, 4'h5, 0, 1, 3'd1, C_DEC,     0, 0, 1));
    apply(mk(0, 4'h5, 0, 1, 3'd2, C_EX_I,    0, 0, 1));
    apply(mk(1, 4'h5, 0, 1, 3'd3, C_MEM_RST, 0, 0, 1));
    apply(mk(1, 4'h5, 0, 1, 3'd0, C_RST,     0, 0, 0));
    apply(mk(0, 4'h7, 0, 1, 3'd0, C_F_RDY,   0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control sequencer for the 16-bit CPU. It drives the program counter's write enable and next-PC source, the instruction register load, memory strobes and register-file and ALU steering, walking each instruction through FETCH / DECODE / EXEC / MEM / WB. It sits beside the datapath, takes the IR opcode, the ALU zero flag and a memory-ready handshake, and counts retired instructions.

## Interface
- `OPC_W`, 4: opcode width (IR[15:12]).
- `CNT_W`, 16: retired-instruction counter width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  OPC_W  current IR opcode; valid from DECODE until the next FETCH.
- `zero`  in  1  ALU zero flag; sampled in EXEC for BEQ.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`  out  1  PC load enable.
- `pc_src`  out  2  next-PC source: 00 ALU result (PC+2), 01 ALUOut (branch target), 10 jump target.
- `ir_write`  out  1  instruction register load.
- `i_or_d`  out  1  memory address source: 0 PC, 1 ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register-file controls.
- `alu_src_a`  out  1  0 PC, 1 reg A.
- `alu_src_b`  out  2  00 reg B, 01 constant 2, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 1.
- `alu_op`  out  2  00 add, 01 subtract, 10 funct-decoded.
- `state`  out  3  current state encoding.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Opcodes: 0x0 R-type, 0x1 ADDI, 0x4 LW, 0x5 SW, 0x8 BEQ, 0xC J, 0xF HALT. All other opcodes are illegal.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 return to FETCH on the next edge.
- **FETCH**: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: alu_src_a=0, alu_src_b=11, alu_op=00 (computes the branch target).
  - J: pc_write=1, pc_src=10, then FETCH.
  - HALT: go to HALT.
  - Illegal: illegal=1, then FETCH.
  - All others: go to EXEC.
- **EXEC**:
  - R-type: a=1, b=00, op=10, then WB.
  - ADDI / LW / SW: a=1, b=10, op=00. ADDI goes to WB; LW and SW go to MEM.
  - BEQ: a=1, b=00, op=01, pc_src=01, pc_write=zero, then FETCH.
- **MEM**: i_or_d=1, with mem_read (LW) or mem_write (SW) held high until mem_ready=1.
  - SW goes to FETCH; LW goes to WB.
- **WB**: reg_write=1. reg_dst=1 for R-type, mem_to_reg=1 for LW. Then FETCH.
- **HALT**: all strobes 0, halted=1. Leaves only on rst.
- Any output not listed for a state is 0 in that state.
- `retired` increments by 1 on every transition into FETCH caused by instruction completion: J, BEQ (taken or not), SW, WB exit.
  - Illegal opcodes and HALT do not increment it.
  - It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset: on a rising edge with rst=1, the next state is FETCH, retired=0 and halted=0.
  - While rst=1, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0 combinationally, so a reset mid-instruction never commits PC, IR, memory or registers.
  - After rst is released, the first FETCH read starts in that cycle.
- Strobes are combinational from state and inputs. pc_write in FETCH and EXEC is Mealy (depends on mem_ready / zero). State, retired and halted are registered.
- Cycles per instruction with mem_ready tied high: J 2, BEQ 3, R-type / ADDI / SW 4, LW 5. Each memory wait cycle adds 1 in FETCH or MEM.
- The memory request stays stable (same strobe, same i_or_d) until mem_ready is sampled high. mem_ready in any other state is ignored.
- `opcode` is ignored in FETCH. The IR changes only on the FETCH exit edge.

## Test plan
- **Reset and fetch**: hold rst=1 for 2 cycles with mem_ready=1.
  - During reset: state=0, retired=0, all strobes 0.
  - First cycle after release: mem_read=1, pc_write=1, ir_write=1.
- **Instruction mix, no waits**: opcode sequence 0x0, 0x1, 0x4, 0x5, 0xC with mem_ready=1.
  - Per-instruction cycle counts: 4, 4, 5, 4, 2.
  - retired reads 5 after the J completes.
  - WB shows reg_dst=1 for R-type and mem_to_reg=1 for LW.
- **BEQ**: run with zero=1, then with zero=0.
  - zero=1: EXEC has pc_write=1, pc_src=01.
  - zero=0: pc_write=0.
  - Both take 3 cycles and both increment retired.
- **Memory waits**: mem_ready=0 for 3 cycles in FETCH, then 2 cycles in MEM of an LW.
  - state holds and mem_read stays 1 throughout.
  - LW takes 10 cycles.
  - ir_write pulses exactly once.
- **Illegal and halt**:
  - opcode 0x7: illegal pulses one cycle in DECODE, returns to FETCH, retired unchanged.
  - opcode 0xF: halted=1 and state=5 persist for 20 cycles with no strobes, until rst.
- **Reset mid-operation**: assert rst in the MEM state of an SW with mem_ready=1.
  - mem_write=0 in that cycle.
  - Next state is 0 and retired is 0.
